rom_fetch_controller: RTL and testbench
=======================================

# rom_fetch_controller

Sequencing controller for the simple CPU. It owns the program counter, instruction register and accumulator. It drives the level-sensitive instruction ROM (addr/read/ena) and the data RAM read port, and runs the fetch–decode–execute cycle. Instruction format is 8 bits: opcode in [7:6], operand address in [5:0]. The block sits between the ROM/RAM and the top-level CPU wrapper.

## Interface
Parameters:
- `ADDR_W`, default 6: ROM/RAM address width.
- `DATA_W`, default 8: instruction, data and accumulator width.
- `PROG_LEN`, default 8: number of valid ROM words. The PC wraps to 0 after `PROG_LEN-1`.

Ports (clock and reset first):
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `run` in 1: start/continue. Sampled in IDLE and at instruction completion.
- `rom_addr` out ADDR_W: ROM address, equal to PC during fetch.
- `rom_read` out 1: ROM read strobe.
- `rom_ena` out 1: ROM enable.
- `rom_data` in DATA_W: ROM output. High-Z when not enabled.
- `ram_addr` out ADDR_W: RAM address, equal to IR[5:0] during ADD.
- `ram_read` out 1: RAM read strobe.
- `ram_ena` out 1: RAM enable.
- `ram_data` in DATA_W: RAM read data.
- `acc` out DATA_W: accumulator.
- `pc` out ADDR_W: program counter.
- `ir` out DATA_W: instruction register.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `instr_done` out 1: one-cycle pulse when an instruction retires.

## Operation
Opcodes:
- 2'b00 HLT
- 2'b01 INC (acc+1)
- 2'b10 DEC (acc−1)
- 2'b11 ADD (acc + RAM[IR[5:0]])

Arithmetic is modulo 2^DATA_W. No flags. Carry and borrow are discarded.

States: IDLE, FETCH, LATCH, EXEC, ACCW, HALT.
- IDLE: all strobes low. If `run`=1, go to FETCH.
- FETCH: `rom_ena`=`rom_read`=1, `rom_addr`=pc. Go to LATCH.
- LATCH: ROM strobes held. `ir` <= `rom_data` at the end of this cycle. Go to EXEC.
- EXEC, by opcode:
  - INC/DEC: update `acc`, update pc, pulse `instr_done`.
  - ADD: `ram_ena`=`ram_read`=1, `ram_addr`=ir[5:0]. Go to ACCW.
  - HLT: go to HALT. pc is not advanced.
- ACCW: RAM strobes held. `acc` <= `acc`+`ram_data`, update pc, pulse `instr_done`.
- Completion (end of EXEC for INC/DEC, end of ACCW for ADD): go to FETCH if `run`=1, else IDLE.
- HALT: absorbing. Ignores `run`. Only `rst` exits.

PC update rule: `pc` <= (pc==PROG_LEN-1) ? 0 : pc+1.

All strobes and addresses are Moore outputs, decoded from the state register and pc/ir only. When not asserted, `rom_addr` and `ram_addr` hold their last value.

Boundary conditions:
- `run` dropping mid-instruction: the current instruction completes, then the block goes to IDLE. pc points to the next instruction.
- `rst` in any state: on the next edge, state=IDLE and all outputs take their reset values. An ADD in progress is abandoned and acc is unchanged from reset.
- `rom_data` is only sampled in LATCH. Content outside 0..PROG_LEN-1 is never fetched.

## Timing
- Reset values: `acc`=0, `pc`=0, `ir`=0, `rom_*`=0, `ram_*`=0, `busy`=0, `halted`=0, `instr_done`=0. State is IDLE.
- FETCH is entered on the edge after `run` is sampled high in IDLE.
- Latency: INC/DEC take 3 cycles (FETCH, LATCH, EXEC). ADD takes 4 cycles (FETCH, LATCH, EXEC, ACCW). HLT takes 3 cycles to reach HALT.
- `instr_done` is registered. It is high in the cycle after the retiring state, the same cycle the new `acc`/`pc` are visible.
- Back-to-back instructions: FETCH of the next instruction coincides with the `instr_done` cycle. There are no bubbles.
- ROM enables are high for exactly 2 cycles per instruction. RAM enables are high for exactly 2 cycles per ADD.

## Structure
- Shared package `simple_cpu_pkg` holds:
  - opcode constants OP_HLT/OP_INC/OP_DEC/OP_ADD
  - the state encoding
  - field positions OPC_MSB/OPC_LSB/OPR_W
- The ROM uses the same constants.
- One sub-module, `cpu_alu`: combinational, takes opcode, acc and operand, returns the next acc.
- The FSM, PC, IR and acc registers stay in the top module.

## Test plan
- Program INC,DEC,INC,DEC,ADD[3],ADD[2],ADD[3],ADD[2] with RAM[2]=0x05 and RAM[3]=0x10, `run` held high.
  - Required: acc after each retire = 01,00,01,00,10,15,25,2A.
  - Required: 8 `instr_done` pulses in 28 cycles, then pc=0 and the next fetch is at address 0.
- Wrap checks:
  - acc=0xFF, INC: acc=0x00.
  - acc=0x00, DEC: acc=0xFF.
  - acc=0xF0, ADD with operand 0x20: acc=0x10.
- HLT at address 2 after INC,INC:
  - Required: acc=0x02, `halted`=1, pc=2, strobes low.
  - Toggling `run` for 20 cycles causes no change.
- Drop `run` during LATCH of an ADD:
  - Required: the ADD completes, `instr_done` pulses once, the block enters IDLE with `busy`=0, pc advanced by 1.
  - Re-asserting `run` resumes from that pc.
- Assert `rst` during ACCW of an ADD:
  - Required: next cycle acc=0, pc=0, ir=0, all strobes 0, no `instr_done`.
- Strobe monitor across the full program: `rom_ena`/`rom_read` high exactly 2 cycles per instruction, `ram_ena`/`ram_read` high only in EXEC/ACCW of ADD, ROM and RAM never enabled in the same cycle.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared constants for the simple CPU: opcodes, instruction field positions
// and the sequencing controller's state encoding.
package simple_cpu_pkg;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 6;
  localparam int unsigned OPR_W   = 6;

  typedef enum logic [1:0] {
    OP_HLT = 2'b00,
    OP_INC = 2'b01,
    OP_DEC = 2'b10,
    OP_ADD = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_ACCW,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator update: next acc from opcode, current acc and operand.
module cpu_alu
  import simple_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [1:0]        opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = acc;
    case (opcode_t'(opcode))
      OP_INC:  result = acc + 1'b1;
      OP_DEC:  result = acc - 1'b1;
      OP_ADD:  result = acc + operand;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/rom_fetch_controller.sv
// Fetch-decode-execute sequencer: owns pc, ir and acc, drives the ROM and the
// RAM read port. All strobes and addresses are registered Moore outputs.
module rom_fetch_controller
  import simple_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PROG_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  output logic              rom_ena,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read,
  output logic              ram_ena,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              busy,
  output logic              halted,
  output logic              instr_done
);

  state_t              state;
  opcode_t             ir_opc;
  opcode_t             fetched_opc;
  logic [DATA_W-1:0]   alu_result;
  logic [ADDR_W-1:0]   pc_next;
  logic                retire;

  assign ir_opc      = opcode_t'(ir[OPC_MSB:OPC_LSB]);
  assign fetched_opc = opcode_t'(rom_data[OPC_MSB:OPC_LSB]);
  assign pc_next     = (pc == ADDR_W'(PROG_LEN - 1)) ? '0 : pc + 1'b1;

  always_comb begin
    retire = 1'b0;
    if (state == S_ACCW)
      retire = 1'b1;
    else if (state == S_EXEC && (ir_opc == OP_INC || ir_opc == OP_DEC))
      retire = 1'b1;
  end

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode  (ir[OPC_MSB:OPC_LSB]),
    .acc     (acc),
    .operand (ram_data),
    .result  (alu_result)
  );

  // Outputs are registered from the upcoming state, so RAM strobes for an ADD
  // are raised while leaving LATCH using the opcode straight off the ROM bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      pc         <= '0;
      ir         <= '0;
      rom_addr   <= '0;
      rom_read   <= 1'b0;
      rom_ena    <= 1'b0;
      ram_addr   <= '0;
      ram_read   <= 1'b0;
      ram_ena    <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      if (retire) begin
        acc        <= alu_result;
        pc         <= pc_next;
        instr_done <= 1'b1;
        ram_ena    <= 1'b0;
        ram_read   <= 1'b0;
        if (run) begin
          state    <= S_FETCH;
          rom_ena  <= 1'b1;
          rom_read <= 1'b1;
          rom_addr <= pc_next;
        end else begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              state    <= S_FETCH;
              rom_ena  <= 1'b1;
              rom_read <= 1'b1;
              rom_addr <= pc;
              busy     <= 1'b1;
            end
          end
          S_FETCH: state <= S_LATCH;
          S_LATCH: begin
            state    <= S_EXEC;
            ir       <= rom_data;
            rom_ena  <= 1'b0;
            rom_read <= 1'b0;
            if (fetched_opc == OP_ADD) begin
              ram_ena  <= 1'b1;
              ram_read <= 1'b1;
              ram_addr <= ADDR_W'(rom_data[OPR_W-1:0]);
            end
          end
          S_EXEC: begin
            if (ir_opc == OP_ADD) begin
              state <= S_ACCW;
            end else begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
          end
          S_HALT: state <= S_HALT;
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_controller.sv
// Bench for rom_fetch_controller: instruction-level ISA model checked every cycle,
// plus directed programs with hand-computed accumulator/pc expectations.
module tb_rom_fetch_controller;
  import simple_cpu_pkg::*;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PROG_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  rom_addr, ram_addr, pc;
  logic        rom_read, rom_ena, ram_read, ram_ena, busy, halted, instr_done;
  logic [7:0]  rom_data, ram_data, acc, ir;

  logic [7:0]  rom [64];
  logic [7:0]  ram [64];
  int          n_cmp = 0;
  int          n_bad = 0;

  rom_fetch_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_LEN(PROG_LEN)) dut (
    .clk(clk), .rst(rst), .run(run),
    .rom_addr(rom_addr), .rom_read(rom_read), .rom_ena(rom_ena), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_ena(ram_ena), .ram_data(ram_data),
    .acc(acc), .pc(pc), .ir(ir), .busy(busy), .halted(halted), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_ena ? rom[rom_addr] : 8'h00;
  assign ram_data = ram_ena ? ram[ram_addr] : 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- instruction-level model, checked every cycle ----------------
  logic [7:0] m_acc = '0;
  logic [5:0] m_pc = '0;
  logic [7:0] m_ins;
  int         rom_cnt = 0;
  int         ram_cnt = 0;
  logic       m_halt = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_acc = '0; m_pc = '0; rom_cnt = 0; ram_cnt = 0; m_halt = 1'b0;
    end else begin
      if (instr_done) begin
        m_ins = rom[m_pc];
        chk("retire_is_hlt", 32'(m_ins[7:6] == 2'b00), 0);
        chk("retire_rom_cycles", rom_cnt, 2);
        chk("retire_ram_cycles", ram_cnt, (m_ins[7:6] == 2'b11) ? 2 : 0);
        chk("retire_ir", ir, m_ins);
        case (m_ins[7:6])
          2'b01:   m_acc = m_acc + 8'd1;
          2'b10:   m_acc = m_acc - 8'd1;
          2'b11:   m_acc = m_acc + ram[m_ins[5:0]];
          default: m_acc = m_acc;
        endcase
        m_pc = (m_pc == 6'(PROG_LEN - 1)) ? 6'd0 : m_pc + 6'd1;
        rom_cnt = 0;
        ram_cnt = 0;
      end
      if (halted && !m_halt) begin
        m_halt = 1'b1;
        chk("halt_op", rom[m_pc][7:6], 0);
        chk("halt_rom_cycles", rom_cnt, 2);
      end
      if (m_halt)
        chk("halt_quiet", {busy, rom_ena, ram_ena, instr_done}, 0);
      chk("acc", acc, m_acc);
      chk("pc", pc, m_pc);
      chk("rom_read_eq_ena", rom_read, rom_ena);
      chk("ram_read_eq_ena", ram_read, ram_ena);
      chk("rom_ram_exclusive", rom_ena & ram_ena, 0);
      if (rom_ena || ram_ena) chk("busy_when_strobing", busy, 1);
      if (rom_ena) begin
        rom_cnt++;
        chk("rom_addr", rom_addr, m_pc);
      end
      if (ram_ena) begin
        ram_cnt++;
        chk("ram_only_for_add", rom[m_pc][7:6], OP_ADD);
        chk("ram_addr", ram_addr, rom[m_pc][5:0]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic sig(input int s);
    case (s)
      0:       return rom_ena;
      1:       return instr_done;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input int s, input string name);
    int k = 0;
    @(negedge clk);
    while (!sig(s) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, 32'(sig(s)), 1);
  endtask

  task automatic do_reset(input logic [63:0] prog);
    rst = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    for (int i = 0; i < 8; i++) rom[i] = prog[63 - 8*i -: 8];
    @(negedge clk);
    @(negedge clk);
    chk("reset_values",
        {acc, pc, ir, rom_addr, ram_addr, rom_ena, rom_read, ram_ena, ram_read, busy, halted, instr_done}, 0);
    rst = 1'b0;
  endtask

  logic [7:0] accq[$];
  logic [7:0] exp1 [8] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h10, 8'h15, 8'h25, 8'h2A};
  logic [7:0] exp2 [4] = '{8'hFF, 8'h00, 8'hF0, 8'h10};
  int         cnt;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    ram[2] = 8'h05; ram[3] = 8'h10; ram[4] = 8'hF0; ram[5] = 8'h20;

    // Full program: INC,DEC,INC,DEC,ADD[3],ADD[2],ADD[3],ADD[2]
    do_reset(64'h40_80_40_80_C3_C2_C3_C2);
    run = 1'b1;
    wait_for(0, "p1_first_fetch");
    accq.delete();
    for (int c = 2; c <= 29; c++) begin
      @(negedge clk);
      if (instr_done) accq.push_back(acc);
    end
    chk("p1_pulses", accq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("p1_acc", (i < accq.size()) ? 32'(accq[i]) : 32'hDEAD, exp1[i]);
    chk("p1_wrap_pc", pc, 0);
    chk("p1_refetch", {rom_ena, rom_addr}, {1'b1, 6'd0});

    // Wrap: DEC from 0, INC from FF, F0+20
    do_reset(64'h80_40_C4_C5_00_00_00_00);
    run = 1'b1;
    accq.delete();
    cnt = 0;
    while (!halted && cnt < 40) begin
      @(negedge clk);
      if (instr_done) accq.push_back(acc);
      cnt++;
    end
    chk("wrap_pulses", accq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("wrap_acc", (i < accq.size()) ? 32'(accq[i]) : 32'hDEAD, exp2[i]);
    chk("wrap_halt_pc", {halted, pc}, {1'b1, 6'd4});

    // HLT at address 2 after INC,INC; run toggling must not disturb HALT
    do_reset(64'h40_40_00_00_00_00_00_00);
    run = 1'b1;
    wait_for(2, "hlt_reach");
    chk("hlt_state", {acc, pc, halted, busy, rom_ena, rom_read, ram_ena, ram_read},
        {8'h02, 6'd2, 1'b1, 1'b0, 4'b0000});
    for (int c = 0; c < 20; c++) begin
      run = ~run;
      @(negedge clk);
      chk("hlt_absorb", {acc, pc, halted, busy, instr_done, rom_ena, ram_ena},
          {8'h02, 6'd2, 1'b1, 4'b0000});
    end

    // Drop run during LATCH of an ADD, then resume
    do_reset(64'h40_C3_40_00_00_00_00_00);
    run = 1'b1;
    wait_for(1, "drop_inc_done");
    chk("drop_inc_acc", acc, 8'h01);
    @(negedge clk);
    chk("drop_latch_strobes", {rom_ena, ram_ena}, 2'b10);
    run = 1'b0;
    wait_for(1, "drop_add_done");
    chk("drop_add_result", {acc, pc, busy}, {8'h11, 6'd2, 1'b0});
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (instr_done || busy || rom_ena) cnt++;
    end
    chk("drop_idle_quiet", cnt, 0);
    run = 1'b1;
    wait_for(0, "resume_fetch");
    chk("resume_addr", rom_addr, 6'd2);
    wait_for(1, "resume_done");
    chk("resume_result", {acc, pc}, {8'h12, 6'd3});

    // Reset during ACCW of an ADD
    do_reset(64'hC3_00_00_00_00_00_00_00);
    run = 1'b1;
    wait_for(0, "rst_fetch");
    @(negedge clk);
    @(negedge clk);
    chk("rst_exec_ram", {ram_ena, ram_read, ram_addr}, {2'b11, 6'd3});
    @(negedge clk);
    chk("rst_accw_ram", {ram_ena, instr_done}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abandon",
        {acc, pc, ir, rom_ena, rom_read, ram_ena, ram_read, busy, halted, instr_done}, 0);
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    chk("rst_after", {acc, instr_done, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
